// File: rtl/riscv_issue_ctl_pkg.sv
// Shared definitions for the issue controller: RV32 opcode map, FSM states
// and decode helpers for register-use classification.
package riscv_issue_ctl_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_BRANCH: uses_rs1 = 1'b1;
      default:                                                      uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

  // Writes to x0 are architecturally discarded, so they never occupy the scoreboard.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic rd_nonzero);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP, OPC_OP_IMM, OPC_LOAD:          writes_rd = rd_nonzero;
      default:                               writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_fence(input logic [6:0] opcode);
    is_fence = (opcode == OPC_MISC_MEM);
  endfunction

endpackage

// File: rtl/riscv_scoreboard.sv
// Per-register pending-writeback bits plus the outstanding-writer counter.
// Read ports see the same-cycle writeback already applied.
module riscv_scoreboard
  import riscv_issue_ctl_pkg::*;
#(
  parameter int REGN         = 32,
  parameter int REGA         = $clog2(REGN),
  parameter int MAX_INFLIGHT = 4,
  parameter int CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [REGA-1:0] set_rd,
  input  logic            clr_en,
  input  logic [REGA-1:0] clr_rd,
  input  logic [REGA-1:0] rs1,
  input  logic [REGA-1:0] rs2,
  input  logic [REGA-1:0] rd,
  output logic            pend_rs1,
  output logic            pend_rs2,
  output logic            pend_rd,
  output logic [CNTW-1:0] inflight,
  output logic [CNTW-1:0] inflight_eff,
  output logic            sb_err
);

  logic [REGN-1:0] pend_q, pend_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            cnt_dec;

  assign pend_rs1 = (rs1 != '0) & pend_q[rs1] & !(clr_en & (clr_rd == rs1));
  assign pend_rs2 = (rs2 != '0) & pend_q[rs2] & !(clr_en & (clr_rd == rs2));
  assign pend_rd  = (rd  != '0) & pend_q[rd]  & !(clr_en & (clr_rd == rd));

  assign cnt_dec      = clr_en & (cnt_q != '0);
  assign inflight_eff = cnt_q - {{(CNTW-1){1'b0}}, cnt_dec};

  // Clear is applied before set so a same-cycle issue to the retiring register keeps its bit.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = inflight_eff;
    err_d  = err_q;
    if (clr_en) begin
      if (!pend_q[clr_rd] || (cnt_q == '0)) begin
        err_d = 1'b1;
      end
      pend_d[clr_rd] = 1'b0;
    end
    if (set_en) begin
      pend_d[set_rd] = 1'b1;
      cnt_d          = inflight_eff + {{(CNTW-1){1'b0}}, 1'b1};
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign inflight = cnt_q;
  assign sb_err   = err_q;

endmodule

// File: rtl/riscv_issue_ctl.sv
// Issue/hazard controller in front of ID: gates instruction capture on
// register hazards, the in-flight limit, FENCE draining and post-redirect hold.
module riscv_issue_ctl
  import riscv_issue_ctl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REGN         = 32,
  parameter int REGA         = $clog2(REGN),
  parameter int MAX_INFLIGHT = 4,
  parameter int CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] instruction,
  output logic            id_issue,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [REGA-1:0] wb_rd,
  output logic            stall,
  output logic [CNTW-1:0] inflight,
  output logic            draining,
  output logic            sb_err
);

  state_e state_q, state_d;

  logic [6:0]      opcode;
  logic [REGA-1:0] rd, rs1, rs2;
  logic            dec_rs1, dec_rs2, dec_wr, dec_fence;
  logic            pend_rs1, pend_rs2, pend_rd;
  logic [CNTW-1:0] inflight_eff;
  logic            hazard, full, pipe_empty;
  logic            run_ok, drain_ok;
  logic            unused_fields;

  assign opcode = instruction[6:0];
  assign rd     = instruction[7 +: REGA];
  assign rs1    = instruction[15 +: REGA];
  assign rs2    = instruction[20 +: REGA];

  assign unused_fields = ^{instruction[XLEN-1:25], instruction[14:12]};

  assign dec_rs1   = uses_rs1(opcode);
  assign dec_rs2   = uses_rs2(opcode);
  assign dec_wr    = writes_rd(opcode, rd != '0);
  assign dec_fence = is_fence(opcode);

  riscv_scoreboard #(
    .REGN         (REGN),
    .REGA         (REGA),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNTW         (CNTW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_en       (id_issue & dec_wr),
    .set_rd       (rd),
    .clr_en       (wb_valid),
    .clr_rd       (wb_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .pend_rs1     (pend_rs1),
    .pend_rs2     (pend_rs2),
    .pend_rd      (pend_rd),
    .inflight     (inflight),
    .inflight_eff (inflight_eff),
    .sb_err       (sb_err)
  );

  // The rd term blocks a second writer to a pending register, keeping each bit single-owner.
  assign hazard     = (dec_rs1 & pend_rs1) | (dec_rs2 & pend_rs2) | (dec_wr & pend_rd);
  assign full       = (inflight_eff == CNTW'(MAX_INFLIGHT));
  assign pipe_empty = (inflight_eff == '0);

  assign run_ok   = (state_q == ST_RUN) & !hazard & !(dec_wr & full) & !(dec_fence & !pipe_empty);
  assign drain_ok = (state_q == ST_DRAIN) & dec_fence & pipe_empty;

  assign if_ready = !rst & !flush & (run_ok | drain_ok);
  assign id_issue = if_valid & if_ready;
  assign stall    = !rst & if_valid & !if_ready & !flush;
  assign draining = (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_HOLD;
        end else if (if_valid & dec_fence & !pipe_empty) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          state_d = ST_HOLD;
        end else if (pipe_empty) begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: doc/riscv_issue_ctl.md
Name: riscv_issue_ctl

Overview:
Issue/hazard controller sitting between instruction fetch and the riscv_id decode stage. It decides each cycle whether the fetched instruction may be captured by ID, using a per-register scoreboard of outstanding writebacks. It also enforces an in-flight limit, drains the pipe for FENCE, and blocks issue for one cycle after a redirect flush. It produces the capture enable for the ID registers and the ready signal back to fetch.

Parameters:
XLEN, 32, instruction/data width
REGN, 32, number of architectural registers
REGA, $clog2(REGN), register index width
MAX_INFLIGHT, 4, max outstanding rd-writing instructions (≥1)
CNTW, $clog2(MAX_INFLIGHT+1), in-flight counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_valid  in  1  fetch presents a valid instruction
if_ready  out  1  controller accepts instruction this cycle (combinational)
instruction  in  XLEN  fetched instruction
id_issue  out  1  capture enable for ID stage; equals if_valid & if_ready
flush  in  1  branch/jump redirect; current fetched instruction discarded
wb_valid  in  1  writeback completing this cycle
wb_rd  in  REGA  writeback destination (never 0 when wb_valid)
stall  out  1  if_valid high but not issued this cycle (combinational)
inflight  out  CNTW  outstanding rd-writers (registered)
draining  out  1  controller is in DRAIN state
sb_err  out  1  sticky: writeback to non-pending reg or with inflight==0

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous, active-high. Reset clears scoreboard, inflight=0, sb_err=0, state=RUN. Outputs with rst high: if_ready=0, id_issue=0, stall=0.
- Decode, from instruction[6:0]:
  - reads rs1: OP, OP_IMM, LOAD, STORE, JALR, BRANCH
  - reads rs2: OP, STORE, BRANCH
  - writes rd: LUI, AUIPC, JAL, JALR, OP, OP_IMM, LOAD, only when rd (bits 11:7) != 0
  - FENCE is MISC_MEM (0001111)
  - Unknown opcodes read nothing, write nothing, and issue normally; ID flags the exception.
- Hazard, combinational: hazard = (uses_rs1 & pend_eff[rs1]) | (uses_rs2 & pend_eff[rs2]).
  - pend_eff = scoreboard with wb_rd cleared when wb_valid (same-cycle writeback bypass; the regfile is write-before-read).
  - x0 is never pending.
- States:
  - RUN → DRAIN: FENCE presented while inflight_eff != 0. The FENCE is not issued.
  - RUN → HOLD: flush=1.
  - DRAIN → RUN: inflight_eff == 0. FENCE issues in the same cycle if if_valid.
  - DRAIN → HOLD: flush.
  - HOLD → RUN: always, after exactly 1 cycle.
- if_ready = !rst & !flush & ((state==RUN & !hazard & !(writes_rd & inflight_eff==MAX_INFLIGHT) & !(fence & inflight_eff!=0)) | (state==DRAIN & fence & inflight_eff==0)).
  - inflight_eff = inflight - (wb_valid & inflight!=0).
- stall = if_valid & !if_ready & !flush.
- Update on issue of a writer:
  - scoreboard[rd] <= 1; inflight +1.
  - Same cycle wb_valid with wb_rd==rd: set wins, bit stays 1, counter net unchanged (+1 −1).
- Writeback:
  - clears scoreboard[wb_rd]; inflight −1.
  - If the bit was already 0 or inflight==0: sb_err <= 1, counter does not underflow.
- WAW: a second writer to a pending rd stalls. This keeps scoreboard bits single-valued.
- flush: no issue that cycle. Scoreboard and counter still take writebacks; in-flight work is not cancelled.
- Latency: issue decision 0 cycles (combinational); scoreboard/inflight visible next cycle.

Decomposition:
- Shared package riscv/isa.v holds the opcode macros (OP, OP_IMM, LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH, MISC_MEM). Add MISC_MEM there if missing.
- Add an instruction-field-use helper (uses_rs1/uses_rs2/writes_rd) as functions in the same include.
- One natural sub-module: riscv_scoreboard (REGN bit vector, set/clear ports, read ports rs1/rs2, in-flight counter). The controller FSM stays in riscv_issue_ctl.

Test Plan:
- RAW stall: issue ADDI x5,x0,1 (0x00100293), then present ADD x6,x5,x5. → stall=1 until wb_valid,wb_rd=5. ADD issues in that same wb cycle; inflight 1→1.
- x0 and rd=0: issue ADDI x0,x0,0 then ADD x1,x0,x0. → both issue back-to-back, inflight stays 0 then 1, no stall.
- In-flight limit: issue 4 independent writers x1..x4, present a 5th (x7). → if_ready=0, inflight=4. A wb of x2 lets x7 issue in that cycle, inflight stays 4.
- FENCE drain: with inflight=2, present FENCE (0x0000000F). → draining=1, stall=1. After two writebacks FENCE issues in the cycle inflight_eff hits 0, state back to RUN.
- Flush: flush=1 with if_valid and a hazard-free instruction. → id_issue=0 that cycle and the next (HOLD); issue resumes on the 2nd cycle. A mid-flush wb still clears its bit.
- Errors/reset: wb_valid with wb_rd=9 not pending → sb_err=1, inflight unchanged. Assert rst for one cycle mid-DRAIN → inflight=0, sb_err=0, state RUN, scoreboard clear.
